// File: rtl/traffic_pkg.sv
// traffic_pkg: definitions shared by the crossing controller and the light
// sequence checker.
//   phase_e          tracker phase encoding (matches the controller)
//   FLT_*            fault codes; a lower number takes priority
//   PAT_*            lamp patterns {ROAD_RED, ROAD_YELLOW, ROAD_GREEN, PED_RED, PED_GREEN}
//   DEF_*            default timing constants, in clock cycles
package traffic_pkg;

  typedef enum logic [2:0] {
    PH_CAR_GREEN      = 3'd0,
    PH_CAR_YELLOW     = 3'd1,
    PH_ALL_RED        = 3'd2,
    PH_PED_GREEN      = 3'd3,
    PH_PED_BLINK      = 3'd4,
    PH_CAR_RED_YELLOW = 3'd5,
    PH_UNKNOWN        = 3'd7
  } phase_e;

  localparam logic [2:0] FLT_NONE               = 3'd0;
  localparam logic [2:0] FLT_CONFLICT           = 3'd1;
  localparam logic [2:0] FLT_ILLEGAL_PATTERN    = 3'd2;
  localparam logic [2:0] FLT_ILLEGAL_TRANSITION = 3'd3;
  localparam logic [2:0] FLT_SHORT_DWELL        = 3'd4;
  localparam logic [2:0] FLT_STUCK              = 3'd5;

  localparam logic [4:0] PAT_CAR_GREEN      = 5'b00101;
  localparam logic [4:0] PAT_CAR_YELLOW     = 5'b01010;
  localparam logic [4:0] PAT_ALL_RED        = 5'b10010;
  localparam logic [4:0] PAT_PED_GREEN      = 5'b10001;
  localparam logic [4:0] PAT_PED_DARK       = 5'b10000;
  localparam logic [4:0] PAT_CAR_RED_YELLOW = 5'b11010;

  localparam int DEF_MIN_GREEN  = 6;
  localparam int DEF_MIN_YELLOW = 2;
  localparam int DEF_MIN_PED    = 5;
  localparam int DEF_MAX_DWELL  = 64;

endpackage

// File: rtl/light_decoder.sv
// light_decoder: combinational lamp pattern decoder.
//   lamp          in  5  {RR, RY, RG, PR, PG}
//   dec_phase     out 3  decoded phase, PH_UNKNOWN when not a phase pattern
//   dec_dark      out 1  pedestrian-dark pattern (blink off half)
//   dec_conflict  out 1  pedestrian green together with road green/yellow
//   dec_illegal   out 1  any other undecodable pattern
module light_decoder
  import traffic_pkg::*;
(
  input  logic [4:0] lamp,
  output logic [2:0] dec_phase,
  output logic       dec_dark,
  output logic       dec_conflict,
  output logic       dec_illegal
);

  always_comb begin
    dec_phase    = PH_UNKNOWN;
    dec_dark     = 1'b0;
    dec_conflict = 1'b0;
    dec_illegal  = 1'b0;
    case (lamp)
      PAT_CAR_GREEN:      dec_phase = PH_CAR_GREEN;
      PAT_CAR_YELLOW:     dec_phase = PH_CAR_YELLOW;
      PAT_ALL_RED:        dec_phase = PH_ALL_RED;
      PAT_PED_GREEN:      dec_phase = PH_PED_GREEN;
      PAT_CAR_RED_YELLOW: dec_phase = PH_CAR_RED_YELLOW;
      PAT_PED_DARK:       dec_dark  = 1'b1;
      default: begin
        // lamp[0] = PED_GREEN, lamp[2] = ROAD_GREEN, lamp[3] = ROAD_YELLOW
        if (lamp[0] && (lamp[2] || lamp[3])) dec_conflict = 1'b1;
        else                                 dec_illegal  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/light_sequence_checker.sv
// light_sequence_checker: watches the lamp drives of a pedestrian crossing
// and flags conflicts, illegal patterns, illegal phase changes, short dwells
// and stuck phases.
//   clk, rst                      clock, synchronous active-high reset
//   ROAD_RED .. PED_GREEN         observed lamp drives
//   clear                         clears the sticky fault
//   phase / phase_valid           tracked phase, valid when not UNKNOWN
//   fault / fault_code            sticky fault and first captured code
//   cycle_count                   completed crossing cycles (RY -> G), saturating
//
// Tracker states:
//   state             | meaning
//   PH_CAR_GREEN      | road green, pedestrians red
//   PH_CAR_YELLOW     | road yellow
//   PH_ALL_RED        | everything red between road and pedestrian phases
//   PH_PED_GREEN      | pedestrian green
//   PH_PED_BLINK      | pedestrian green blinking (dark seen after green)
//   PH_CAR_RED_YELLOW | road red+yellow, about to go green
//   PH_UNKNOWN        | no history (after reset)
module light_sequence_checker
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN  = DEF_MIN_GREEN,
  parameter int MIN_YELLOW = DEF_MIN_YELLOW,
  parameter int MIN_PED    = DEF_MIN_PED,
  parameter int MAX_DWELL  = DEF_MAX_DWELL
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ROAD_RED,
  input  logic        ROAD_YELLOW,
  input  logic        ROAD_GREEN,
  input  logic        PED_RED,
  input  logic        PED_GREEN,
  input  logic        clear,
  output logic [2:0]  phase,
  output logic        phase_valid,
  output logic        fault,
  output logic [2:0]  fault_code,
  output logic [15:0] cycle_count
);

  localparam int              DW_W      = $clog2(MAX_DWELL + 1);
  localparam logic [DW_W-1:0] DWELL_MAX = DW_W'(MAX_DWELL);
  localparam logic [DW_W-1:0] DWELL_ONE = DW_W'(1);

  logic [4:0]      lamp_q;
  // The reset value of the input register (all lamps off) is not a real
  // observation, so nothing is checked until a sampled pattern is present.
  logic            lamp_vld;

  phase_e          phase_q, phase_d;
  phase_e          last_q, last_d;
  phase_e          target;
  logic [DW_W-1:0] dwell_q, dwell_d;
  logic            chk_q, chk_d;
  logic [2:0]      flt_new;
  logic            fault_d;
  logic [2:0]      code_d;
  logic [15:0]     cnt_d;

  logic [2:0]      dec_phase;
  logic            dec_dark;
  logic            dec_conflict;
  logic            dec_illegal;

  light_decoder u_decoder (
    .lamp         (lamp_q),
    .dec_phase    (dec_phase),
    .dec_dark     (dec_dark),
    .dec_conflict (dec_conflict),
    .dec_illegal  (dec_illegal)
  );

  function automatic logic [DW_W-1:0] min_dwell(input phase_e p);
    case (p)
      PH_CAR_GREEN:      min_dwell = DW_W'(MIN_GREEN);
      PH_CAR_YELLOW,
      PH_ALL_RED,
      PH_CAR_RED_YELLOW: min_dwell = DW_W'(MIN_YELLOW);
      PH_PED_GREEN:      min_dwell = DW_W'(MIN_PED);
      default:           min_dwell = '0;
    endcase
  endfunction

  // Leaving all-red is only legal towards the side that did not just run;
  // UNKNOWN history allows either side.
  function automatic logic trans_legal(input phase_e src, input phase_e dst, input phase_e last);
    case (src)
      PH_CAR_GREEN:      trans_legal = (dst == PH_CAR_YELLOW);
      PH_CAR_YELLOW:     trans_legal = (dst == PH_ALL_RED);
      PH_ALL_RED:        trans_legal =
                           ((dst == PH_PED_GREEN) &&
                            (last == PH_CAR_YELLOW || last == PH_UNKNOWN)) ||
                           ((dst == PH_CAR_RED_YELLOW) &&
                            (last == PH_PED_GREEN || last == PH_PED_BLINK || last == PH_UNKNOWN));
      PH_PED_GREEN:      trans_legal = (dst == PH_PED_BLINK) || (dst == PH_ALL_RED);
      PH_PED_BLINK:      trans_legal = (dst == PH_ALL_RED);
      PH_CAR_RED_YELLOW: trans_legal = (dst == PH_CAR_GREEN);
      PH_UNKNOWN:        trans_legal = 1'b1;
      default:           trans_legal = 1'b0;
    endcase
  endfunction

  always_comb begin
    target  = phase_q;
    flt_new = FLT_NONE;
    phase_d = phase_q;
    last_d  = last_q;
    dwell_d = dwell_q;
    chk_d   = chk_q;
    cnt_d   = cycle_count;
    fault_d = fault;
    code_d  = fault_code;

    if (lamp_vld) begin
      // Undecodable patterns leave target at the current phase, so the
      // phase holds and the dwell keeps counting.
      if (dec_conflict) begin
        flt_new = FLT_CONFLICT;
      end else if (dec_illegal) begin
        flt_new = FLT_ILLEGAL_PATTERN;
      end else if (dec_dark) begin
        target = PH_PED_BLINK;
      end else if (phase_q == PH_PED_BLINK && phase_e'(dec_phase) == PH_PED_GREEN) begin
        target = PH_PED_BLINK;
      end else begin
        target = phase_e'(dec_phase);
      end

      if (target != phase_q) begin
        if (!trans_legal(phase_q, target, last_q))
          flt_new = FLT_ILLEGAL_TRANSITION;
        else if (chk_q && dwell_q < min_dwell(phase_q))
          flt_new = FLT_SHORT_DWELL;
        if (phase_q == PH_CAR_RED_YELLOW && target == PH_CAR_GREEN && cycle_count != 16'hFFFF)
          cnt_d = cycle_count + 16'd1;
        if (phase_q != PH_ALL_RED)
          last_d = phase_q;
        chk_d   = (phase_q != PH_UNKNOWN);
        dwell_d = DWELL_ONE;
        phase_d = target;
      end else if (phase_q != PH_UNKNOWN && dwell_q != DWELL_MAX) begin
        dwell_d = dwell_q + DWELL_ONE;
        if (dwell_d == DWELL_MAX && flt_new == FLT_NONE)
          flt_new = FLT_STUCK;
      end
    end

    // A new fault wins over clear; otherwise only the first code is kept.
    if (flt_new != FLT_NONE) begin
      if (!fault || clear) begin
        fault_d = 1'b1;
        code_d  = flt_new;
      end
    end else if (clear) begin
      fault_d = 1'b0;
      code_d  = FLT_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lamp_q      <= '0;
      lamp_vld    <= 1'b0;
      phase_q     <= PH_UNKNOWN;
      last_q      <= PH_UNKNOWN;
      dwell_q     <= '0;
      chk_q       <= 1'b0;
      phase_valid <= 1'b0;
      fault       <= 1'b0;
      fault_code  <= FLT_NONE;
      cycle_count <= '0;
    end else begin
      lamp_q      <= {ROAD_RED, ROAD_YELLOW, ROAD_GREEN, PED_RED, PED_GREEN};
      lamp_vld    <= 1'b1;
      phase_q     <= phase_d;
      last_q      <= last_d;
      dwell_q     <= dwell_d;
      chk_q       <= chk_d;
      phase_valid <= (phase_d != PH_UNKNOWN);
      fault       <= fault_d;
      fault_code  <= code_d;
      cycle_count <= cnt_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: tb/tb_light_sequence_checker.sv
// Self-checking bench for light_sequence_checker: directed scenarios plus a
// randomized lamp walk, all compared every cycle against a reference model.
module tb_light_sequence_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rr = 1'b0, ry = 1'b0, rg = 1'b0, pr = 1'b0, pg = 1'b0;
  logic        clear = 1'b0;
  logic [2:0]  phase;
  logic        phase_valid;
  logic        fault;
  logic [2:0]  fault_code;
  logic [15:0] cycle_count;

  always #5 clk = ~clk;

  light_sequence_checker dut (
    .clk         (clk),
    .rst         (rst),
    .ROAD_RED    (rr),
    .ROAD_YELLOW (ry),
    .ROAD_GREEN  (rg),
    .PED_RED     (pr),
    .PED_GREEN   (pg),
    .clear       (clear),
    .phase       (phase),
    .phase_valid (phase_valid),
    .fault       (fault),
    .fault_code  (fault_code),
    .cycle_count (cycle_count)
  );

  localparam logic [4:0] G  = 5'b00101;
  localparam logic [4:0] Y  = 5'b01010;
  localparam logic [4:0] AR = 5'b10010;
  localparam logic [4:0] PG = 5'b10001;
  localparam logic [4:0] DK = 5'b10000;
  localparam logic [4:0] RY = 5'b11010;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model: phases as plain ints (7 = unknown), pipeline of one
  // registered pattern in front of the tracker.
  bit   legal_tbl [0:7][0:7];
  int   min_tbl   [0:7] = '{6, 2, 2, 5, 0, 2, 0, 0};
  int   m_phase, m_last, m_dwell, m_fault, m_code, m_cnt;
  bit   m_chk, m_vld;
  logic [4:0] m_pat;

  // 0..5 phases, 10 pedestrian dark, 20 conflict, 21 illegal
  function automatic int decode(input logic [4:0] p);
    case (p)
      5'b00101: return 0;
      5'b01010: return 1;
      5'b10010: return 2;
      5'b10001: return 3;
      5'b11010: return 5;
      5'b10000: return 10;
      default:  return (p[0] && (p[2] || p[3])) ? 20 : 21;
    endcase
  endfunction

  task automatic model_step(input logic [4:0] pat, input bit clr, input bit r);
    int d, tgt, code;
    bit ok;
    if (r) begin
      m_phase = 7; m_last = 7; m_dwell = 0; m_chk = 0;
      m_fault = 0; m_code = 0; m_cnt = 0; m_vld = 0; m_pat = '0;
      return;
    end
    code = 0;
    if (m_vld) begin
      d   = decode(m_pat);
      tgt = m_phase;
      if (d == 20)                      code = 1;
      else if (d == 21)                 code = 2;
      else if (d == 10)                 tgt  = 4;
      else if (d == 3 && m_phase == 4)  tgt  = 4;
      else                              tgt  = d;
      if (tgt != m_phase) begin
        if (m_phase == 7)      ok = 1;
        else if (m_phase == 2) ok = (tgt == 3 && (m_last == 1 || m_last == 7)) ||
                                    (tgt == 5 && (m_last == 3 || m_last == 4 || m_last == 7));
        else                   ok = legal_tbl[m_phase][tgt];
        if (!ok) code = 3;
        else if (m_chk && m_dwell < min_tbl[m_phase]) code = 4;
        if (m_phase == 5 && tgt == 0 && m_cnt < 65535) m_cnt++;
        if (m_phase != 2) m_last = m_phase;
        m_chk   = (m_phase != 7);
        m_dwell = 1;
        m_phase = tgt;
      end else if (m_phase != 7 && m_dwell < 64) begin
        m_dwell++;
        if (m_dwell == 64 && code == 0) code = 5;
      end
    end
    if (code != 0) begin
      if (!m_fault || clr) begin m_fault = 1; m_code = code; end
    end else if (clr) begin
      m_fault = 0; m_code = 0;
    end
    m_pat = pat;
    m_vld = 1;
  endtask

  task automatic cyc(input logic [4:0] pat, input bit clr, input bit r);
    {rr, ry, rg, pr, pg} = pat;
    clear = clr;
    rst   = r;
    @(posedge clk);
    model_step(pat, clr, r);
    #1;
    chk("phase",       int'(phase),       m_phase);
    chk("phase_valid", int'(phase_valid), (m_phase != 7) ? 1 : 0);
    chk("fault",       int'(fault),       m_fault);
    chk("fault_code",  int'(fault_code),  m_code);
    chk("cycle_count", int'(cycle_count), m_cnt);
  endtask

  task automatic hold(input logic [4:0] pat, input int n);
    for (int i = 0; i < n; i++) cyc(pat, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    cyc(G, 1'b0, 1'b1);
    cyc(G, 1'b0, 1'b1);
  endtask

  logic [4:0] nominal [0:6];

  initial begin
    legal_tbl[0][1] = 1;
    legal_tbl[1][2] = 1;
    legal_tbl[3][4] = 1;
    legal_tbl[3][2] = 1;
    legal_tbl[4][2] = 1;
    legal_tbl[5][0] = 1;
    nominal = '{G, Y, AR, PG, DK, AR, RY};

    // reset state
    do_reset();
    chk("rst_phase",       int'(phase),       7);
    chk("rst_phase_valid", int'(phase_valid), 0);
    chk("rst_fault",       int'(fault),       0);
    chk("rst_fault_code",  int'(fault_code),  0);
    chk("rst_cycle_count", int'(cycle_count), 0);

    // nominal crossing cycle
    hold(G, 6); hold(Y, 2); hold(AR, 2); hold(PG, 5); hold(DK, 1);
    hold(PG, 1); hold(AR, 2); hold(RY, 2); hold(G, 2);
    chk("nom_phase", int'(phase),       0);
    chk("nom_fault", int'(fault),       0);
    chk("nom_count", int'(cycle_count), 1);

    // short green (entered from RY, so it is dwell-checked)
    hold(G, 1);
    hold(Y, 1);
    chk("short_early", int'(fault), 0);
    hold(Y, 1);
    chk("short_fault", int'(fault),      1);
    chk("short_code",  int'(fault_code), 4);

    // new fault coinciding with clear replaces the held code
    cyc(5'b00000, 1'b0, 1'b0);
    cyc(Y, 1'b1, 1'b0);
    chk("clr_new_fault", int'(fault),      1);
    chk("clr_new_code",  int'(fault_code), 2);
    cyc(Y, 1'b1, 1'b0);
    chk("clr_fault", int'(fault),      0);
    chk("clr_code",  int'(fault_code), 0);

    // conflict, visible on the second edge
    do_reset();
    hold(G, 3);
    cyc(5'b00111, 1'b0, 1'b0);
    chk("conf_early", int'(fault), 0);
    cyc(5'b00111, 1'b0, 1'b0);
    chk("conf_fault", int'(fault),      1);
    chk("conf_code",  int'(fault_code), 1);

    // AR after Y must not go to RY
    do_reset();
    hold(G, 6); hold(Y, 2); hold(AR, 2); hold(RY, 2);
    chk("trans_code", int'(fault_code), 3);

    // stuck green
    do_reset();
    hold(G, 70);
    chk("stuck_code", int'(fault_code), 5);

    // reset mid pedestrian green discards history
    do_reset();
    hold(G, 6); hold(Y, 2); hold(AR, 2); hold(PG, 3);
    cyc(PG, 1'b0, 1'b1);
    hold(AR, 3);
    chk("rst_mid_phase", int'(phase),       2);
    chk("rst_mid_valid", int'(phase_valid), 1);
    chk("rst_mid_fault", int'(fault),       0);
    hold(RY, 3);
    chk("rst_mid_ry_fault", int'(fault), 0);
    chk("rst_mid_ry_phase", int'(phase), 5);

    // randomized walk around the nominal sequence with disturbances
    do_reset();
    begin
      int idx;
      idx = 0;
      for (int s = 0; s < 400; s++) begin
        int         r, len;
        logic [4:0] pat;
        r = $urandom_range(0, 99);
        if (r < 8)       pat = 5'($urandom_range(0, 31));
        else if (r < 12) pat = nominal[$urandom_range(0, 6)];
        else begin
          pat = nominal[idx];
          idx = (idx + 1) % 7;
        end
        len = ($urandom_range(0, 99) < 3) ? $urandom_range(60, 70) : $urandom_range(1, 8);
        if ($urandom_range(0, 99) < 2) cyc(pat, 1'b0, 1'b1);
        for (int k = 0; k < len; k++)
          cyc(pat, ($urandom_range(0, 99) < 5) ? 1'b1 : 1'b0, 1'b0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/light_sequence_checker.md
LIGHT_SEQUENCE_CHECKER -- requirements
Module: light_sequence_checker

Interface
REQ-001 The module SHALL have parameter MIN_GREEN, default 6, the minimum dwell in cycles for CAR_GREEN.
REQ-002 The module SHALL have parameter MIN_YELLOW, default 2, the minimum dwell in cycles for CAR_YELLOW, ALL_RED and CAR_RED_YELLOW.
REQ-003 The module SHALL have parameter MIN_PED, default 5, the minimum dwell in cycles for PED_GREEN.
REQ-004 The module SHALL have parameter MAX_DWELL, default 64, the watchdog limit in cycles for any single phase.
REQ-005 Ports SHALL be, clock and reset first:
  clk  in  1  clock; all logic is on the rising edge.
  rst  in  1  synchronous, active-high reset.
  ROAD_RED, ROAD_YELLOW, ROAD_GREEN, PED_RED, PED_GREEN  in  1 each  observed lamp drives.
  clear  in  1  clears the sticky fault.
  phase  out  3  decoded phase.
  phase_valid  out  1  phase is tracked.
  fault  out  1  sticky fault flag.
  fault_code  out  3  first fault captured.
  cycle_count  out  16  completed crossing cycles.

Function
REQ-006 The five lamp inputs SHALL be registered once; all checks SHALL use the registered copy.
REQ-007 All outputs SHALL be registered, so a fault SHALL assert on the 2nd rising edge after the offending pattern appears at the inputs.
REQ-008 The lamp pattern (RR,RY,RG,PR,PG) SHALL decode as:
  00101 = CAR_GREEN (0)
  01010 = CAR_YELLOW (1)
  10010 = ALL_RED (2)
  10001 = PED_GREEN (3)
  10000 = PED_DARK
  11010 = CAR_RED_YELLOW (5)
  any other pattern = ILLEGAL.
REQ-009 The tracker phase encodings SHALL be 0 to 5 as above, plus PED_BLINK = 4 and UNKNOWN = 7.
REQ-010 PED_DARK SHALL move PED_GREEN or PED_BLINK to PED_BLINK.
REQ-011 While in PED_BLINK, a PED_GREEN pattern SHALL keep phase at PED_BLINK.
REQ-012 The legal phase transitions SHALL be exactly:
  G to Y
  Y to AR
  AR to PG, only if the last non-AR phase was Y or UNKNOWN
  AR to RY, only if the last non-AR phase was PG, PED_BLINK or UNKNOWN
  PG to PED_BLINK
  PG to AR
  PED_BLINK to AR
  RY to G
REQ-013 An unchanged pattern SHALL never be a transition.
REQ-014 Fault codes SHALL be:
  1 CONFLICT: PED_GREEN=1 together with ROAD_GREEN or ROAD_YELLOW.
  2 ILLEGAL_PATTERN: any other undecodable pattern.
  3 ILLEGAL_TRANSITION: a phase change not listed in REQ-012.
  4 SHORT_DWELL: the phase is left before its minimum dwell.
  5 STUCK: the dwell counter reaches MAX_DWELL.
REQ-015 If several faults occur in the same cycle, fault_code SHALL take the lowest code number.
REQ-016 fault SHALL be sticky, and fault_code SHALL hold the first fault until clear.
REQ-017 A clear asserted in the same cycle as a new fault SHALL leave fault set, with the new fault's code.
REQ-018 A dwell counter SHALL reset to 1 on each phase change, increment otherwise, and saturate at MAX_DWELL.
REQ-019 PED_BLINK and UNKNOWN SHALL have no minimum dwell check.
REQ-020 The first phase entered from UNKNOWN SHALL NOT be dwell-checked.
REQ-021 After any fault, the tracker SHALL continue to follow decodable patterns.
REQ-022 After an ILLEGAL pattern, the phase SHALL hold its prior value.
REQ-023 cycle_count SHALL increment on each legal RY to G transition and saturate at 16'hFFFF.
REQ-024 phase_valid SHALL be 1 whenever phase is not UNKNOWN.

Reset
REQ-025 While rst is high at a clock edge, the following SHALL hold on the next cycle:
  phase = 7 (UNKNOWN)
  phase_valid = 0
  fault = 0
  fault_code = 0
  cycle_count = 0
  dwell counter = 0
  input register = 0
  last-non-AR phase = UNKNOWN
REQ-026 A reset mid-sequence SHALL discard all history, and tracking SHALL restart as from UNKNOWN.

Structure
REQ-027 Package traffic_pkg SHALL hold the phase enum (shared encoding with the controller), the fault-code constants and the default timing constants.
REQ-028 The combinational pattern decoder SHALL be a separate sub-module, light_decoder.

Verification
REQ-029 Drive the controller's nominal sequence (G 6, Y 2, AR 2, PG 5, dark 1, PG 1, AR 2, RY 2, G) -> fault stays 0, phase follows 0,1,2,3,4,4,2,5,0, and cycle_count becomes 1.
REQ-030 Force 00101 then 00111 -> fault=1, fault_code=1, two edges later.
REQ-031 Go G to Y after 3 cycles of G -> fault_code=4; then pulse clear -> fault returns to 0.
REQ-032 Drive AR entered from Y, then 11010 (RY) -> fault_code=3.
REQ-033 Hold 00101 for 70 cycles from a known phase -> fault_code=5 at dwell 64.
REQ-034 Apply rst mid-PED_GREEN, then drive 10010 -> phase=2, phase_valid=1, no fault; then 11010 -> no fault, because the last non-AR phase is UNKNOWN.
